// File: rtl/tag_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// tag_stage_skid_reg
//
// Inter-stage register for the multibit-tree tag sorter. It moves the matching
// tag, backup matching tag, forwarded incoming tag and backup incoming tag
// between tree stages as one payload. The stage has a valid/ready handshake and
// a two-entry skid buffer, so that downstream back-pressure never reaches
// upstream through a combinational path.
//
// Parameters
//   MATCH_W  width of the matching-tag and backup-matching-tag fields
//   FWD_W    width of the forwarded incoming-tag field
//   BAK_W    width of the backup incoming-tag field
//   CNT_W    width of the saturating stall counter
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   flush           drops every buffered entry and any input in this cycle
//   in_valid/ready  upstream handshake (in_ready comes from a register only)
//   in_*            incoming payload fields
//   out_valid/ready downstream handshake
//   out_*           registered payload, taken from the main entry
//   stall_cnt       saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module tag_stage_skid_reg #(
    parameter int MATCH_W = 4,
    parameter int FWD_W   = 12,
    parameter int BAK_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MATCH_W-1:0] in_match_tag,
    input  logic [MATCH_W-1:0] in_match_bak,
    input  logic [FWD_W-1:0]   in_tag_fwd,
    input  logic [BAK_W-1:0]   in_tag_bak,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MATCH_W-1:0] out_match_tag,
    output logic [MATCH_W-1:0] out_match_bak,
    output logic [FWD_W-1:0]   out_tag_fwd,
    output logic [BAK_W-1:0]   out_tag_bak,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int PL_W = 2 * MATCH_W + FWD_W + BAK_W;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic [PL_W-1:0]  w_in_pl;
    logic [PL_W-1:0]  r_main_pl_p0;
    logic [PL_W-1:0]  r_skid_pl_p0;
    logic             r_main_vld_p0;
    logic             r_skid_vld_p0;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_accept;
    logic             w_release;
    logic             w_stall;

    assign w_in_pl = {in_match_tag, in_match_bak, in_tag_fwd, in_tag_bak};

    // The skid valid bit is the only source of in_ready. The stage can take an
    // entry whenever the skid slot is free, regardless of out_ready.
    assign in_ready  = !r_skid_vld_p0;
    assign out_valid = r_main_vld_p0;
    assign {out_match_tag, out_match_bak, out_tag_fwd, out_tag_bak} = r_main_pl_p0;
    assign stall_cnt = r_stall_cnt;

    // A flushed input is never accepted, even when in_ready is high.
    assign w_accept  = in_valid && !r_skid_vld_p0 && !flush;
    assign w_release = r_main_vld_p0 && out_ready;
    assign w_stall   = r_main_vld_p0 && !out_ready;

    // ---- stage p0: main/skid storage ----
    // States are encoded by the valid bits: EMPTY (0,0), ONE (1,0), TWO (1,1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld_p0 <= 1'b0;
            r_skid_vld_p0 <= 1'b0;
            r_main_pl_p0  <= '0;
            r_skid_pl_p0  <= '0;
            r_stall_cnt   <= '0;
        end else begin
            // flush does not touch the counter; it only affects the valid bits.
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end

            if (flush) begin
                // Payload registers keep stale data; only the valids drop.
                r_main_vld_p0 <= 1'b0;
                r_skid_vld_p0 <= 1'b0;
            end else if (!r_main_vld_p0) begin
                // EMPTY: an accepted entry goes straight into main.
                if (w_accept) begin
                    r_main_pl_p0  <= w_in_pl;
                    r_main_vld_p0 <= 1'b1;
                end
            end else if (!r_skid_vld_p0) begin
                // ONE
                if (w_accept && w_release) begin
                    r_main_pl_p0 <= w_in_pl;
                end else if (w_accept) begin
                    r_skid_pl_p0  <= w_in_pl;
                    r_skid_vld_p0 <= 1'b1;
                end else if (w_release) begin
                    r_main_vld_p0 <= 1'b0;
                end
            end else begin
                // TWO: in_ready is low, so the only move is skid into main.
                if (w_release) begin
                    r_main_pl_p0  <= r_skid_pl_p0;
                    r_skid_vld_p0 <= 1'b0;
                end
            end
        end
    end

endmodule
